// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - point-to-point move sequencer: ramps a setpoint to a target, waits for settle, times out to FAULT.
// Setpoint arithmetic is done in 17 bits so 16-bit extremes never wrap.
module move_sequencer #(
  parameter int STEP           = 4,
  parameter int TICK_DIV       = 50000,
  parameter int TOL            = 8,
  parameter int SETTLE_CYCLES  = 100000,
  parameter int TIMEOUT_CYCLES = 24000000
) (
  input  logic        clk,
  input  logic        rst_raw,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_target,
  output logic        cmd_ready,
  input  logic        abort,
  input  logic [15:0] position,
  output logic [15:0] setpoint,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_SETTLE, S_FAULT} state_t;

  state_t      state_q;
  logic [15:0] setpoint_q;
  logic [15:0] target_q;
  logic [31:0] tick_q;
  logic [31:0] settle_q;
  logic [31:0] timeout_q;
  logic        done_q;

  logic [16:0] diff, err, diff_abs, err_abs;
  logic [15:0] step_sp_d;
  logic [31:0] timeout_d;
  logic        ready, accept, tick_hit, in_tol, settle_hit, timeout_hit;

  assign diff     = {target_q[15], target_q} - {setpoint_q[15], setpoint_q};
  assign err      = {target_q[15], target_q} - {position[15], position};
  assign diff_abs = diff[16] ? (~diff + 17'd1) : diff;
  assign err_abs  = err[16] ? (~err + 17'd1) : err;

  // Only used when |diff| > STEP, so the step can never overshoot or wrap.
  assign step_sp_d = diff[16] ? (setpoint_q - 16'(STEP)) : (setpoint_q + 16'(STEP));
  assign timeout_d = (timeout_q == 32'hFFFF_FFFF) ? timeout_q : (timeout_q + 32'd1);

  assign ready       = (state_q == S_IDLE) || (state_q == S_FAULT);
  assign accept      = cmd_valid && ready && !abort;
  assign tick_hit    = (tick_q == 32'(TICK_DIV - 1));
  assign in_tol      = (err_abs <= 17'(TOL));
  assign settle_hit  = in_tol && (settle_q == 32'(SETTLE_CYCLES - 1));
  assign timeout_hit = (timeout_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) begin
      state_q    <= S_IDLE;
      setpoint_q <= '0;
      target_q   <= '0;
      tick_q     <= '0;
      settle_q   <= '0;
      timeout_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FAULT: begin
          // FAULT zeroes controller drive by commanding the measured position.
          if (state_q == S_FAULT) setpoint_q <= position;
          if (accept) begin
            target_q  <= cmd_target;
            tick_q    <= '0;
            settle_q  <= '0;
            timeout_q <= '0;
            state_q   <= S_RAMP;
          end
        end
        S_RAMP: begin
          timeout_q <= timeout_d;
          if (abort) begin
            state_q <= S_IDLE;
          end else if (timeout_hit) begin
            state_q <= S_FAULT;
          end else begin
            tick_q <= tick_hit ? '0 : (tick_q + 32'd1);
            if (tick_hit) begin
              if (diff_abs <= 17'(STEP)) begin
                setpoint_q <= target_q;
                state_q    <= S_SETTLE;
              end else begin
                setpoint_q <= step_sp_d;
              end
            end
          end
        end
        S_SETTLE: begin
          timeout_q <= timeout_d;
          if (abort) begin
            state_q <= S_IDLE;
          end else if (settle_hit) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            state_q <= S_FAULT;
          end else begin
            settle_q <= in_tol ? (settle_q + 32'd1) : '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = ready;
  assign busy      = (state_q == S_RAMP) || (state_q == S_SETTLE);
  assign fault     = (state_q == S_FAULT);
  assign done      = done_q;
  assign setpoint  = setpoint_q;

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 The block SHALL take parameter STEP, default 4: setpoint increment per ramp tick, positive, in encoder counts.
REQ-002 The block SHALL take parameter TICK_DIV, default 50000: clk cycles per ramp tick, at least 1.
REQ-003 The block SHALL take parameter TOL, default 8: settle tolerance, in counts, at least 0.
REQ-004 The block SHALL take parameter SETTLE_CYCLES, default 100000: consecutive in-tolerance cycles required for completion.
REQ-005 The block SHALL take parameter TIMEOUT_CYCLES, default 24000000: maximum cycles allowed in RAMP plus SETTLE.
REQ-006 clk  in  1  the single system clock; all state changes on its rising edge.
REQ-007 rst_raw  in  1  asynchronous, active-low reset.
REQ-008 cmd_valid  in  1  a move request is present.
REQ-009 cmd_target  in  16 signed  requested target position, in counts.
REQ-010 cmd_ready  out  1  the block can accept a move request.
REQ-011 abort  in  1  stop the current move.
REQ-012 position  in  16 signed  measured encoder position.
REQ-013 setpoint  out  16 signed  position command to the P controller.
REQ-014 busy  out  1  high in RAMP or SETTLE.
REQ-015 done  out  1  one-cycle pulse when a move completes.
REQ-016 fault  out  1  high in FAULT (the move timed out).

Function
REQ-017 The state machine SHALL have the states IDLE, RAMP, SETTLE and FAULT, encoded in a registered state variable.
REQ-018 cmd_ready SHALL be 1 exactly in IDLE and FAULT; busy SHALL be 1 exactly in RAMP and SETTLE; fault SHALL be 1 exactly in FAULT.
REQ-019 A command SHALL be accepted on a cycle with cmd_valid=1, cmd_ready=1 and abort=0; cmd_target is latched into an internal target register.
REQ-020 On acceptance, the next state SHALL be RAMP; the tick, settle and timeout counters SHALL clear to 0.
REQ-021 In RAMP, the tick counter SHALL count 0 to TICK_DIV-1 and wrap; a ramp tick occurs on the cycle it equals TICK_DIV-1.
REQ-022 On a ramp tick, the block SHALL compute diff = target - setpoint in 17-bit signed arithmetic (no overflow at 16-bit extremes).
REQ-023 On a ramp tick with |diff| <= STEP, setpoint SHALL equal target and the next state SHALL be SETTLE; otherwise setpoint SHALL move toward target by STEP.
REQ-024 A target equal to the current setpoint SHALL complete the ramp on the first tick, with setpoint unchanged.
REQ-025 In SETTLE, err = target - position SHALL be computed in 17 bits; |err| <= TOL increments the settle counter, otherwise the settle counter clears.
REQ-026 When the settle counter reaches SETTLE_CYCLES-1 with |err| <= TOL, the next state SHALL be IDLE and done SHALL pulse high for exactly that transition cycle's successor (one cycle).
REQ-027 The timeout counter SHALL increment every cycle in RAMP or SETTLE and saturate; reaching TIMEOUT_CYCLES-1 SHALL force the next state to FAULT.
REQ-028 In FAULT, setpoint SHALL track position each cycle, giving zero drive; FAULT SHALL exit only via command acceptance or reset.
REQ-029 abort=1 in RAMP or SETTLE SHALL force the next state to IDLE, freeze setpoint at its current value and suppress done.
REQ-030 abort in IDLE or FAULT SHALL have no effect other than blocking acceptance.
REQ-031 Priority in one cycle, highest first: abort, settle completion, timeout, ramp tick.
REQ-032 cmd_valid in RAMP or SETTLE SHALL be ignored; commands are not queued.
REQ-033 In IDLE, setpoint SHALL hold its last value.

Reset
REQ-034 While rst_raw=0, the block SHALL hold state=IDLE, setpoint=0, all counters=0, target=0, done=0, with cmd_ready=1, busy=0, fault=0.
REQ-035 Reset asserted mid-move SHALL take effect immediately (asynchronously), without a done pulse.
REQ-036 The first acceptance SHALL be possible on the first rising edge after rst_raw returns to 1.

Verification (STEP=4, TICK_DIV=2, TOL=2, SETTLE_CYCLES=3, TIMEOUT_CYCLES=100)
REQ-037 Target 10, position following setpoint: setpoint 4, 8, 10 on successive ticks (every 2 cycles), then SETTLE; done pulses once after 3 in-tolerance cycles; busy then 0.
REQ-038 Target -32767 from setpoint 32767: setpoint decreases monotonically by 4 with no wrap and ends exactly at -32767.
REQ-039 Target 40 with position stuck at 0: fault=1 after 100 busy cycles, setpoint follows position; a new command (target 0) clears fault and is accepted.
REQ-040 abort asserted while setpoint=8 on the way to 40: state IDLE next cycle, setpoint stays 8, no done pulse; cmd_valid with abort in the same IDLE cycle is not accepted.
REQ-041 In SETTLE, position oscillating 10, 13, 10, 10, 10 around target 10: the settle counter restarts at the 13, and done occurs only after three consecutive in-tolerance samples.
REQ-042 rst_raw pulled low during RAMP: outputs take their reset values asynchronously; after release, cmd_ready=1 and setpoint=0.
